// File: rtl/crossbar_req_issuer.sv
// Requester-side front end for one crossbar input port.
// Buffers outgoing transactions in a small FIFO and presents the head as a
// normal request. A head that waits too long is escalated to a one-hot
// priority request on its destination out-port.
module crossbar_req_issuer #(
   parameter  int N_OUT_PORTS   = 8,
   parameter  int DATA_W        = 32,
   parameter  int DEPTH         = 4,
   parameter  int STARVE_THRESH = 16,
   parameter  int CNT_W         = 8,
   localparam int PORT_W        = $clog2(N_OUT_PORTS),
   localparam int PTR_W         = $clog2(DEPTH),
   localparam int OCC_W         = PTR_W + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [PORT_W-1:0]      in_out_port,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   req,
   output logic [PORT_W-1:0]      req_out_port,
   output logic [DATA_W-1:0]      req_data,
   input  logic                   grant,
   output logic [N_OUT_PORTS-1:0] priority_req,
   input  logic [N_OUT_PORTS-1:0] priority_grant,
   output logic [OCC_W-1:0]       occupancy,
   output logic [CNT_W-1:0]       wait_cnt,
   output logic                   starve_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ESC  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]    occ_q, occ_d;
   logic [CNT_W-1:0]    wait_q, wait_d;
   logic                starve_q, starve_d;

   logic [PORT_W-1:0]   mem_port_q [DEPTH];
   logic [DATA_W-1:0]   mem_data_q [DEPTH];

   logic                push;
   logic                pop;
   logic [PORT_W-1:0]   head_port;
   logic [DATA_W-1:0]   head_data;
   logic                entries_remain;

   // in_ready comes straight from the registered occupancy, so a pop in the
   // same cycle cannot open the FIFO for a push until the following cycle.
   assign in_ready  = (occ_q != OCC_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign head_port = mem_port_q[rd_ptr_q];
   assign head_data = mem_data_q[rd_ptr_q];

   // After a pop the FIFO still holds something if more than one entry was
   // present, or a push lands in the same cycle.
   assign entries_remain = (occ_q > OCC_W'(1)) || push;

   // Next-state, wait counter and request outputs.
   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      starve_d     = 1'b0;
      pop          = 1'b0;
      req          = 1'b0;
      priority_req = '0;
      unique case (state_q)
         ST_IDLE: begin
            wait_d = '0;
            if ((occ_q != '0) || push) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            req = 1'b1;
            if (grant) begin
               pop     = 1'b1;
               wait_d  = '0;
               state_d = entries_remain ? ST_REQ : ST_IDLE;
            end else if (wait_q == CNT_W'(STARVE_THRESH - 1)) begin
               state_d  = ST_ESC;
               wait_d   = CNT_W'(STARVE_THRESH);
               starve_d = 1'b1;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         ST_ESC: begin
            // Normal grant is ignored here; only the priority grant on the
            // head's own out-port retires the escalated entry.
            priority_req = N_OUT_PORTS'(1) << head_port;
            if (priority_grant[head_port]) begin
               pop     = 1'b1;
               wait_d  = '0;
               state_d = entries_remain ? ST_REQ : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            wait_d  = '0;
         end
      endcase
   end

   // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Control registers: state, pointers, occupancy, wait counter, pulse.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         wait_q   <= '0;
         starve_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         occ_q    <= occ_d;
         wait_q   <= wait_d;
         starve_q <= starve_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // FIFO storage written on push.
   // NOTE: the storage array is deliberately not reset; occupancy and the
   // pointers decide which slots are valid, so clearing the data is wasted logic.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_port_q[wr_ptr_q] <= in_out_port;
         mem_data_q[wr_ptr_q] <= in_data;
      end
   end

   // Head fields are forced to zero while idle so stale slots never leak out.
   assign req_out_port = (state_q != ST_IDLE) ? head_port : '0;
   assign req_data     = (state_q != ST_IDLE) ? head_data : '0;
   assign occupancy    = occ_q;
   assign wait_cnt     = wait_q;
   assign starve_pulse = starve_q;

`ifndef SYNTHESIS
   a_req_excl : assert property (@(posedge clk) disable iff (!rst)
      !(req && (|priority_req)));
   a_prio_onehot : assert property (@(posedge clk) disable iff (!rst)
      $countones(priority_req) <= 1);
   a_occ_bound : assert property (@(posedge clk) disable iff (!rst)
      occupancy <= OCC_W'(DEPTH));
`endif

endmodule

// File: tb/tb_crossbar_req_issuer.sv
// Directed bench for crossbar_req_issuer with a FIFO scoreboard: accepted
// pushes are queued, and the head outputs are compared against the queue
// front whenever the bench grants the head.
module tb_crossbar_req_issuer;

   localparam int N_OUT_PORTS   = 8;
   localparam int DATA_W        = 32;
   localparam int DEPTH         = 4;
   localparam int STARVE_THRESH = 16;
   localparam int CNT_W         = 8;
   localparam int PORT_W        = $clog2(N_OUT_PORTS);
   localparam int OCC_W         = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [PORT_W-1:0]      in_out_port;
   logic [DATA_W-1:0]      in_data;
   logic                   req;
   logic [PORT_W-1:0]      req_out_port;
   logic [DATA_W-1:0]      req_data;
   logic                   grant;
   logic [N_OUT_PORTS-1:0] priority_req;
   logic [N_OUT_PORTS-1:0] priority_grant;
   logic [OCC_W-1:0]       occupancy;
   logic [CNT_W-1:0]       wait_cnt;
   logic                   starve_pulse;

   entry_t sb[$];
   int     n_assert = 0;
   int     n_fail   = 0;

   crossbar_req_issuer #(
      .N_OUT_PORTS  (N_OUT_PORTS),
      .DATA_W       (DATA_W),
      .DEPTH        (DEPTH),
      .STARVE_THRESH(STARVE_THRESH),
      .CNT_W        (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_out_port   (in_out_port),
      .in_data       (in_data),
      .req           (req),
      .req_out_port  (req_out_port),
      .req_data      (req_data),
      .grant         (grant),
      .priority_req  (priority_req),
      .priority_grant(priority_grant),
      .occupancy     (occupancy),
      .wait_cnt      (wait_cnt),
      .starve_pulse  (starve_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Set inputs just after an edge and let combinational outputs settle.
   task automatic drive(input logic v, input logic [PORT_W-1:0] p, input logic [DATA_W-1:0] d,
                        input logic g, input logic [N_OUT_PORTS-1:0] pg);
      in_valid       = v;
      in_out_port    = p;
      in_data        = d;
      grant          = g;
      priority_grant = pg;
      #1;
   endtask

   // Advance one clock; the model accepts a push only when it holds fewer
   // than DEPTH entries before the edge, and pops when the bench says so.
   task automatic tick(input bit pop);
      bit     acc;
      entry_t e;
      acc    = in_valid && (sb.size() < DEPTH);
      e.port = in_out_port;
      e.data = in_data;
      @(posedge clk);
      if (pop && sb.size() > 0) sb.delete(0);
      if (acc) sb.push_back(e);
      #1;
   endtask

   task automatic chk_head(input string tag);
      check({tag, "_port"}, req_out_port, sb[0].port);
      check({tag, "_data"}, req_data, sb[0].data);
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0);
      #1;
      check("rst_occ", occupancy, 0);
      check("rst_req", req, 0);
      check("rst_prio", priority_req, 0);
      check("rst_ready", in_ready, 1);
      check("rst_starve", starve_pulse, 0);
      check("rst_wait", wait_cnt, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single transaction: push at cycle 0, grant at cycle 2.
      @(posedge clk);
      #1;
      drive(1'b1, 3'd3, 32'hA5, 1'b0, '0);
      check("t1_c0_req", req, 0);
      tick(0);
      drive(1'b0, '0, '0, 1'b0, '0);
      check("t1_c1_req", req, 1);
      check("t1_c1_port", req_out_port, 3);
      check("t1_c1_occ", occupancy, 1);
      chk_head("t1_c1");
      tick(0);
      drive(1'b0, '0, '0, 1'b1, '0);
      check("t1_c2_req", req, 1);
      check("t1_c2_wait", wait_cnt, 1);
      chk_head("t1_c2");
      tick(1);
      drive(1'b0, '0, '0, 1'b0, '0);
      check("t1_c3_req", req, 0);
      check("t1_c3_occ", occupancy, sb.size());
      check("t1_c3_port0", req_out_port, 0);

      // Grant and stray priority grants while idle: nothing happens.
      drive(1'b0, '0, '0, 1'b1, 8'hFF);
      tick(0);
      drive(1'b0, '0, '0, 1'b0, '0);
      check("idle_grant_occ", occupancy, 0);
      check("idle_grant_req", req, 0);
      check("idle_grant_prio", priority_req, 0);

      // Fill to DEPTH with a fifth push that must be dropped.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, PORT_W'(i), 32'h100 + i, 1'b0, '0);
         check($sformatf("fill_ready_%0d", i), in_ready, (i < DEPTH) ? 1 : 0);
         tick(0);
      end
      drive(1'b0, '0, '0, 1'b0, '0);
      check("fill_occ", occupancy, 4);
      check("fill_model_occ", occupancy, sb.size());
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, '0, 1'b1, '0);
         check($sformatf("drain_req_%0d", i), req, 1);
         check($sformatf("drain_exp_%0d", i), req_data, 32'h100 + i);
         chk_head($sformatf("drain_%0d", i));
         tick(1);
      end
      drive(1'b0, '0, '0, 1'b0, '0);
      check("drain_occ", occupancy, 0);
      check("drain_req", req, 0);

      // Starvation on port 5.
      drive(1'b1, 3'd5, 32'h55, 1'b0, '0);
      tick(0);
      drive(1'b0, '0, '0, 1'b0, '0);
      for (int i = 0; i < STARVE_THRESH; i++) begin
         check($sformatf("starve_req_%0d", i), req, 1);
         check($sformatf("starve_wait_%0d", i), wait_cnt, i);
         check($sformatf("starve_prio_%0d", i), priority_req, 0);
         tick(0);
      end
      // First ESC cycle, with a priority grant on the wrong port.
      drive(1'b0, '0, '0, 1'b0, 8'h04);
      check("esc_req", req, 0);
      check("esc_prio", priority_req, 8'b0010_0000);
      check("esc_pulse", starve_pulse, 1);
      check("esc_wait", wait_cnt, STARVE_THRESH);
      chk_head("esc");
      tick(0);
      // Still escalated; normal grant is ignored here.
      drive(1'b0, '0, '0, 1'b1, '0);
      check("esc2_prio", priority_req, 8'b0010_0000);
      check("esc2_pulse", starve_pulse, 0);
      check("esc2_occ", occupancy, 1);
      check("esc2_req", req, 0);
      tick(0);
      drive(1'b0, '0, '0, 1'b0, 8'h20);
      check("esc3_prio", priority_req, 8'b0010_0000);
      check("esc3_occ", occupancy, 1);
      chk_head("esc3");
      tick(1);
      drive(1'b0, '0, '0, 1'b0, '0);
      check("esc_pop_wait", wait_cnt, 0);
      check("esc_pop_prio", priority_req, 0);
      check("esc_pop_occ", occupancy, 0);
      check("esc_pop_req", req, 0);

      // Full FIFO: push alongside a pop is refused, then accepted next cycle.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, PORT_W'(i), 32'h200 + i, 1'b0, '0);
         tick(0);
      end
      drive(1'b1, 3'd7, 32'h2AA, 1'b1, '0);
      check("fullpp_ready", in_ready, 0);
      check("fullpp_occ", occupancy, 4);
      chk_head("fullpp_a");
      tick(1);
      drive(1'b1, 3'd6, 32'h2BB, 1'b1, '0);
      check("fullpp_ready_b", in_ready, 1);
      check("fullpp_occ_b", occupancy, 3);
      chk_head("fullpp_b");
      tick(1);
      drive(1'b0, '0, '0, 1'b0, '0);
      check("fullpp_occ_c", occupancy, 3);
      check("fullpp_model", occupancy, sb.size());
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, '0, 1'b1, '0);
         chk_head($sformatf("fullpp_drain_%0d", i));
         if (i == 2) check("fullpp_new_head", req_data, 32'h2BB);
         tick(1);
      end
      drive(1'b0, '0, '0, 1'b0, '0);
      check("fullpp_empty", occupancy, 0);

      // Reset while escalated with three entries buffered.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd5, 32'h300 + i, 1'b0, '0);
         tick(0);
      end
      drive(1'b0, '0, '0, 1'b0, '0);
      for (int i = 0; i < 40; i++) begin
         if (priority_req != '0) break;
         tick(0);
      end
      check("rstesc_prio_pre", priority_req, 8'b0010_0000);
      check("rstesc_occ_pre", occupancy, 3);
      rst = 1'b0;
      #1;
      sb.delete();
      check("rstesc_occ", occupancy, 0);
      check("rstesc_prio", priority_req, 0);
      check("rstesc_req", req, 0);
      check("rstesc_ready", in_ready, 1);
      check("rstesc_pulse", starve_pulse, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_occ", occupancy, 0);
      check("post_rst_req", req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
